// File: rtl/dds_sine_generator_if.sv
// Sample-stream and control bundle for the DDS sine source.
// Combinational only; no latency of its own.
// valid/ready on the sample side; controls are sampled by the slave when it advances.
//
// Signals:
//   phase_inc  phase step per accepted sample (unsigned)
//   gain       amplitude, unsigned Q1.15, values above 1.0 saturate
//   phase_rst  synchronous clear of the phase accumulator
//   ready      consumer accepts the current sample
//   valid      out holds a valid sample
//   out        signed two's-complement sample
interface dds_sine_generator_if #(
  parameter int DATA_W  = 24,
  parameter int PHASE_W = 24
);
  logic [PHASE_W-1:0] phase_inc;
  logic [15:0]        gain;
  logic               phase_rst;
  logic               ready;
  logic               valid;
  logic [DATA_W-1:0]  out;

  // master: drives controls and consumes samples
  modport master (
    output phase_inc, gain, phase_rst, ready,
    input  valid, out
  );

  // slave: the sine generator itself
  modport slave (
    input  phase_inc, gain, phase_rst, ready,
    output valid, out
  );
endinterface

// File: rtl/dds_sine_generator.sv
// Direct-digital-synthesis sine source: phase accumulator -> quarter-wave ROM -> gain.
// Latency: three advances from accumulator phase to out.
// Backpressure: the whole pipeline, accumulator included, holds while valid && !ready.
//
// Ports:
//   clk    clock
//   reset  asynchronous active-high reset; discards any in-flight sample
//   bus    dds_sine_generator_if.slave (phase_inc, gain, phase_rst, ready -> valid, out)
//
// The quarter-wave table is computed at elaboration from its closed form
// round((2^(DATA_W-1)-1) * sin(pi/2 * (k+0.5)/N)), so it becomes a constant ROM.
module dds_sine_generator #(
  parameter int DATA_W     = 24,
  parameter int PHASE_W    = 24,
  parameter int LUT_ADDR_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  dds_sine_generator_if.slave  bus
);

  localparam int N      = 1 << LUT_ADDR_W;
  localparam int MAG_W  = DATA_W - 1;
  localparam int PROD_W = DATA_W + 17;

  // Taylor series of sin on [0, pi/2]; twelve terms are far below one LSB.
  function automatic logic [MAG_W-1:0] quarter_sine(input int k);
    real x;
    real term;
    real sum;
    real amp;
    x    = 3.14159265358979323846 / 2.0 * (real'(k) + 0.5) / real'(N);
    term = x;
    sum  = x;
    for (int n = 1; n < 12; n++) begin
      term = -term * x * x / real'((2 * n) * (2 * n + 1));
      sum  = sum + term;
    end
    amp = real'((longint'(1) << MAG_W) - 1);
    return MAG_W'($rtoi(sum * amp + 0.5));
  endfunction

  logic [MAG_W-1:0] lut [N];

  for (genvar k = 0; k < N; k++) begin : g_lut
    localparam logic [MAG_W-1:0] ENTRY = quarter_sine(k);
    assign lut[k] = ENTRY;
  end

  // Pipeline registers
  logic [PHASE_W-1:0]    acc_q;
  logic [LUT_ADDR_W-1:0] addr1_q;
  logic                  neg1_q;
  logic                  s1_vld_q;
  logic [MAG_W-1:0]      mag2_q;
  logic                  neg2_q;
  logic                  s2_vld_q;
  logic [DATA_W-1:0]     out_q;
  logic                  valid_q;

  // Next-state / combinational
  logic                     adv;
  logic [PHASE_W-1:0]       acc_d;
  logic [1:0]               quad;
  logic [LUT_ADDR_W-1:0]    idx;
  logic [LUT_ADDR_W-1:0]    addr_d;
  logic signed [DATA_W-1:0] mag_ext;
  logic signed [DATA_W-1:0] samp;
  logic signed [16:0]       gain_sat;
  logic signed [PROD_W-1:0] prod;
  logic [DATA_W-1:0]        out_d;

  // Advance whenever the output slot is empty or being consumed.
  assign adv = !valid_q || bus.ready;

  // Stage 0: phase accumulator, clear wins over increment.
  assign acc_d = bus.phase_rst ? '0 : acc_q + bus.phase_inc;

  // Stage 1 decode: odd quadrants read the table mirrored (N-1-i == ~i),
  // the upper half-cycle negates.
  assign quad   = acc_q[PHASE_W-1 -: 2];
  assign idx    = acc_q[PHASE_W-3 -: LUT_ADDR_W];
  assign addr_d = quad[0] ? ~idx : idx;

  // Stage 3: sign, saturate gain at 1.0, scale. The arithmetic shift floors,
  // and with |gain| <= 1.0 the result always fits DATA_W bits.
  assign mag_ext  = $signed({1'b0, mag2_q});
  assign samp     = neg2_q ? -mag_ext : mag_ext;
  assign gain_sat = (bus.gain > 16'h8000) ? 17'sh08000 : $signed({1'b0, bus.gain});
  assign prod     = samp * gain_sat;
  assign out_d    = DATA_W'(prod >>> 15);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q    <= '0;
      addr1_q  <= '0;
      neg1_q   <= 1'b0;
      s1_vld_q <= 1'b0;
      mag2_q   <= '0;
      neg2_q   <= 1'b0;
      s2_vld_q <= 1'b0;
      out_q    <= '0;
      valid_q  <= 1'b0;
    end else if (adv) begin
      acc_q    <= acc_d;
      addr1_q  <= addr_d;
      neg1_q   <= quad[1];
      s1_vld_q <= 1'b1;
      mag2_q   <= lut[addr1_q];
      neg2_q   <= neg1_q;
      s2_vld_q <= s1_vld_q;
      out_q    <= out_d;
      valid_q  <= s2_vld_q;
    end
  end

  assign bus.valid = valid_q;
  assign bus.out   = out_q;

endmodule

// File: tb/tb_dds_sine_generator.sv
// Scoreboard bench for dds_sine_generator: each run pushes its expected sample
// stream, and an independent monitor pops and compares every accepted sample.
module tb_dds_sine_generator;

  localparam int DATA_W     = 24;
  localparam int PHASE_W    = 24;
  localparam int LUT_ADDR_W = 8;
  localparam int N          = 1 << LUT_ADDR_W;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  dds_sine_generator_if #(.DATA_W(DATA_W), .PHASE_W(PHASE_W)) bus ();

  dds_sine_generator #(
    .DATA_W    (DATA_W),
    .PHASE_W   (PHASE_W),
    .LUT_ADDR_W(LUT_ADDR_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int sb_q[$];
  int mon_idx = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Quarter-wave table straight from its definition.
  function automatic int ref_lut(input int k);
    real x;
    x = 3.14159265358979323846 / 2.0 * (real'(k) + 0.5) / real'(N);
    return $rtoi(8388607.0 * $sin(x) + 0.5);
  endfunction

  // Expected sample for a given phase and gain.
  function automatic int model(input logic [PHASE_W-1:0] ph, input logic [15:0] gain);
    logic [1:0]            q;
    logic [LUT_ADDR_W-1:0] i;
    int                    a;
    int                    s;
    longint                g;
    longint                p;
    q = ph[PHASE_W-1 -: 2];
    i = ph[PHASE_W-3 -: LUT_ADDR_W];
    a = q[0] ? (N - 1 - int'(i)) : int'(i);
    s = q[1] ? -ref_lut(a) : ref_lut(a);
    g = (gain > 16'h8000) ? 64'd32768 : longint'(gain);
    p = longint'(s) * g;
    return int'(p >>> 15);
  endfunction

  function automatic int dut_out();
    return int'($signed(bus.out));
  endfunction

  // Monitor: compare every sample handed over on valid && ready.
  always @(negedge clk) begin
    if (!reset && bus.valid && bus.ready && sb_q.size() > 0) begin
      int e;
      e = sb_q.pop_front();
      check($sformatf("sample[%0d]", mon_idx), dut_out(), e);
      mon_idx++;
    end
  end

  // Reset, queue n expected samples (phase restarts at sample rst_at, if any),
  // release, and check the three-edge fill latency.
  task automatic start_run(input logic [PHASE_W-1:0] inc, input logic [15:0] gain,
                           input int n, input int rst_at);
    logic [PHASE_W-1:0] ph;
    #2;
    reset         = 1'b1;
    bus.ready     = 1'b1;
    bus.phase_rst = 1'b0;
    bus.phase_inc = inc;
    bus.gain      = gain;
    sb_q.delete();
    mon_idx = 0;
    ph = '0;
    for (int j = 0; j < n; j++) begin
      if (j == rst_at) ph = '0;
      sb_q.push_back(model(ph, gain));
      ph = ph + inc;
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("latency_edge1_valid", int'(bus.valid), 0);
    @(negedge clk);
    check("latency_edge2_valid", int'(bus.valid), 0);
    @(negedge clk);
    check("latency_edge3_valid", int'(bus.valid), 1);
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while (sb_q.size() > 0 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    check({"drain_", name}, sb_q.size(), 0);
    sb_q.delete();
  endtask

  initial begin
    reset         = 1'b1;
    bus.ready     = 1'b1;
    bus.phase_rst = 1'b0;
    bus.phase_inc = '0;
    bus.gain      = 16'h8000;
    #1;
    check("reset_valid", int'(bus.valid), 0);
    check("reset_out", dut_out(), 0);

    // Full cycle of the wave; sample 1024 wraps back to sample 0.
    start_run(24'h004000, 16'h8000, 1025, -1);
    drain("full_cycle");

    // Ten-cycle stall mid-stream: output frozen, nothing lost or repeated.
    start_run(24'h004000, 16'h8000, 300, -1);
    repeat (100) @(posedge clk);
    #1 bus.ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("stall_valid", int'(bus.valid), 1);
      check("stall_out", dut_out(), sb_q[0]);
    end
    @(posedge clk);
    #1 bus.ready = 1'b1;
    drain("stall");

    // Gain: half, saturating above 1.0, and an odd value exercising the floor.
    start_run(24'h004000, 16'h4000, 1024, -1);
    drain("gain_half");
    start_run(24'h004000, 16'hFFFF, 1024, -1);
    drain("gain_sat");
    start_run(24'h012345, 16'h6001, 500, -1);
    drain("gain_odd");

    // Phase clear accepted on the advance that produces sample 300.
    start_run(24'h004000, 16'h8000, 400, 300);
    repeat (296) @(posedge clk);
    #1 bus.phase_rst = 1'b1;
    @(posedge clk);
    #1 bus.phase_rst = 1'b0;
    drain("phase_rst");

    // Asynchronous reset between edges clears the output at once.
    start_run(24'h004000, 16'h8000, 1000, -1);
    repeat (50) @(posedge clk);
    #1;
    check("pre_async_valid", int'(bus.valid), 1);
    #1 reset = 1'b1;
    #1;
    check("async_rst_valid", int'(bus.valid), 0);
    check("async_rst_out", dut_out(), 0);
    sb_q.delete();
    start_run(24'h004000, 16'h8000, 20, -1);
    drain("after_async");

    // phase_inc=0 holds lut[0] = round(8388607*sin(pi/1024)) = 25736.
    start_run(24'h000000, 16'h8000, 20, -1);
    check("const_lut0", dut_out(), 25736);
    drain("inc_zero");

    // Half-cycle step alternates +lut[0], -lut[0].
    start_run(24'h800000, 16'h8000, 20, -1);
    check("alt_first", dut_out(), 25736);
    @(negedge clk);
    check("alt_second", dut_out(), -25736);
    drain("inc_half");

    // Half-cycle step at half gain: +/-12868.
    start_run(24'h800000, 16'h4000, 20, -1);
    check("alt_half_first", dut_out(), 12868);
    @(negedge clk);
    check("alt_half_second", dut_out(), -12868);
    drain("inc_half_gain");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
